// File: rtl/udma_tx_prefetch_fifo_pkg.sv
// Shared definitions for the uDMA TX prefetch FIFO.
// Holds the channel state type used by the top and by anything that observes it.
package udma_tx_pkg;

    // Channel states: idle, fetching from L2, or draining after a flush.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } tx_pf_state_e;

endpackage

// File: rtl/udma_tx_prefetch_fifo_if.sv
// Handshake bundle of the TX prefetch FIFO.
// The master side is the FIFO; the slave side is the uDMA core plus the peripheral.
interface udma_tx_prefetch_fifo_if #(
    parameter int DATA_WIDTH = 32
) ();

    // L2 read request / response path
    logic                  req_o;
    logic                  gnt_i;
    logic                  valid_i;
    logic [DATA_WIDTH-1:0] data_i;

    // Stream towards the peripheral
    logic [DATA_WIDTH-1:0] dst_data_o;
    logic                  dst_valid_o;
    logic                  dst_ready_i;

    modport master (
        output req_o,
        input  gnt_i,
        input  valid_i,
        input  data_i,
        output dst_data_o,
        output dst_valid_o,
        input  dst_ready_i
    );

    modport slave (
        input  req_o,
        output gnt_i,
        output valid_i,
        output data_i,
        input  dst_data_o,
        input  dst_valid_o,
        output dst_ready_i
    );

endinterface

// File: rtl/udma_tx_fifo_mem.sv
// Storage array of the TX prefetch FIFO.
// One gated write port, one asynchronous read port; cleared on reset and on flush
// so the read port never shows stale words after either event.
module udma_tx_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  srst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Entry storage: cleared on reset/flush, written only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/udma_tx_prefetch_fifo_chk.sv
// Protocol and occupancy checks for the TX prefetch FIFO.
module udma_tx_prefetch_fifo_chk #(
    parameter int DEPTH = 8,
    parameter int LOG   = 4
) (
    input logic           clk,
    input logic           rst_n,
    input logic           valid,
    input logic           push,
    input logic [LOG-1:0] cnt,
    input logic [LOG-1:0] outst
);

    localparam logic [LOG-1:0] FULL_L = LOG'(DEPTH);

    // A response must always match a previously granted request.
    a_resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        valid |-> (outst != {LOG{1'b0}}));

    // Credit scheme guarantees there is always room for a response.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (cnt != FULL_L));

    // Stored plus in-flight words never exceed the buffer size.
    a_credit_non_negative: assert property (@(posedge clk) disable iff (!rst_n)
        (int'(cnt) + int'(outst)) <= DEPTH);

endmodule

// File: rtl/udma_tx_prefetch_fifo.sv
// uDMA TX prefetch FIFO.
// Issues L2 read requests only while there is a free slot for every in-flight
// response, stores the returned words and streams them to the peripheral.
module udma_tx_prefetch_fifo
    import udma_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    en_i,
    input  logic                    clr_i,
    output logic                    busy_o,
    udma_tx_prefetch_fifo_if.master bus
);

    localparam int LOG   = $clog2(BUFFER_DEPTH) + 1;
    localparam int PTR_W = LOG - 1;

    localparam logic [LOG-1:0]   DEPTH_L  = LOG'(BUFFER_DEPTH);
    localparam logic [LOG-1:0]   ZERO_L   = {LOG{1'b0}};
    localparam logic [LOG-1:0]   ONE_L    = LOG'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    generate
        if ((BUFFER_DEPTH < 2) || ((BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("udma_tx_prefetch_fifo: BUFFER_DEPTH must be a power of two >= 2");
        end
    endgenerate

    tx_pf_state_e          state_r;
    tx_pf_state_e          state_nxt_s;
    logic [LOG-1:0]        cnt_r;
    logic [LOG-1:0]        cnt_nxt_s;
    logic [LOG-1:0]        outst_r;
    logic [LOG-1:0]        outst_nxt_s;
    logic [LOG-1:0]        credit_s;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic                  req_s;
    logic                  grant_s;
    logic                  resp_s;
    logic                  push_s;
    logic                  pop_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    // Credit and handshake qualification; a flush overrides push and pop.
    always_comb begin
        credit_s = DEPTH_L - cnt_r - outst_r;
        req_s    = (state_r == FETCH) && (credit_s != ZERO_L);
        grant_s  = req_s && bus.gnt_i;
        resp_s   = bus.valid_i && (outst_r != ZERO_L);
        push_s   = resp_s && (state_r != FLUSH) && !clr_i;
        pop_s    = (cnt_r != ZERO_L) && bus.dst_ready_i && !clr_i;
    end

    // Next values of the stored-entry and in-flight counters.
    always_comb begin
        outst_nxt_s = outst_r;
        if (grant_s && !resp_s) begin
            outst_nxt_s = outst_r + ONE_L;
        end else if (resp_s && !grant_s) begin
            outst_nxt_s = outst_r - ONE_L;
        end else begin
            outst_nxt_s = outst_r;
        end

        cnt_nxt_s = cnt_r;
        if (clr_i) begin
            cnt_nxt_s = ZERO_L;
        end else if (push_s && !pop_s) begin
            cnt_nxt_s = cnt_r + ONE_L;
        end else if (pop_s && !push_s) begin
            cnt_nxt_s = cnt_r - ONE_L;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Channel state: flush wins, and leaves once every in-flight response is drained.
    always_comb begin
        state_nxt_s = state_r;
        if (clr_i) begin
            state_nxt_s = FLUSH;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = en_i ? FETCH : IDLE;
                FETCH:   state_nxt_s = en_i ? FETCH : IDLE;
                FLUSH:   state_nxt_s = (outst_nxt_s == ZERO_L) ? IDLE : FLUSH;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // State, counters and pointers; a flush rewinds the pointers but keeps outst.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r  <= IDLE;
            cnt_r    <= ZERO_L;
            outst_r  <= ZERO_L;
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            outst_r <= outst_nxt_s;
            if (clr_i) begin
                wr_ptr_r <= PTR_ZERO;
                rd_ptr_r <= PTR_ZERO;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
        end
    end

    udma_tx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .srst  (clr_i),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (bus.data_i),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    udma_tx_prefetch_fifo_chk #(
        .DEPTH (BUFFER_DEPTH),
        .LOG   (LOG)
    ) u_chk (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .valid (bus.valid_i),
        .push  (push_s),
        .cnt   (cnt_r),
        .outst (outst_r)
    );

    assign bus.req_o       = req_s;
    assign bus.dst_valid_o = (cnt_r != ZERO_L);
    assign bus.dst_data_o  = rd_data_s;
    assign busy_o          = (cnt_r != ZERO_L) || (outst_r != ZERO_L) || (state_r == FLUSH);

endmodule

// File: tb/tb_udma_tx_prefetch_fifo.sv
// Self-checking bench for udma_tx_prefetch_fifo: queue-level reference model compared
// every cycle, an in-order L2 responder with fixed 3-cycle latency, and directed phases.
module tb_udma_tx_prefetch_fifo;
    import udma_tx_pkg::*;

    localparam int DW = 32;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rstn_i;
    logic en_i;
    logic clr_i;
    logic busy_o;

    udma_tx_prefetch_fifo_if #(.DATA_WIDTH(DW)) bif ();

    udma_tx_prefetch_fifo #(.DATA_WIDTH(DW), .BUFFER_DEPTH(D)) dut (
        .clk_i  (clk),
        .rstn_i (rstn_i),
        .en_i   (en_i),
        .clr_i  (clr_i),
        .busy_o (busy_o),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: stored words, in-flight count, mode 0=idle 1=fetch 2=flush
    logic [DW-1:0] mq[$];
    int            m_outst = 0;
    int            m_mode  = 0;

    bit            grant_seen = 1'b0;
    logic [DW-1:0] resp_data;
    logic [2:0]    resp_pipe;
    bit            seq_chk = 1'b0;
    logic [DW-1:0] pop_expect;
    int            pop_cnt   = 0;
    int            grant_cnt = 0;
    int            disc_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare DUT outputs with the model, then advance the model over the next edge.
    initial begin : compare_proc
        bit exp_req;
        bit exp_valid;
        bit exp_busy;
        bit g;
        bit r;
        forever begin
            @(negedge clk);
            if (!rstn_i) begin
                mq.delete();
                m_outst    = 0;
                m_mode     = 0;
                grant_seen = 1'b0;
            end
            exp_req   = (m_mode == 1) && ((D - mq.size() - m_outst) > 0);
            exp_valid = (mq.size() != 0);
            exp_busy  = (mq.size() != 0) || (m_outst != 0) || (m_mode == 2);
            check("req_o", bif.req_o, exp_req);
            check("dst_valid_o", bif.dst_valid_o, exp_valid);
            check("busy_o", busy_o, exp_busy);
            if (exp_valid) begin
                check("dst_data_o", bif.dst_data_o, mq[0]);
            end else if (!rstn_i) begin
                check("dst_data_o_reset", bif.dst_data_o, 64'h0);
            end
            if (rstn_i) begin
                g = exp_req && bif.gnt_i;
                r = bif.valid_i && (m_outst > 0);
                grant_seen = g;
                if (g) grant_cnt++;
                if (r && (clr_i || m_mode == 2)) disc_cnt++;
                if (seq_chk && !clr_i && bif.dst_valid_o && bif.dst_ready_i) begin
                    check("pop_order", bif.dst_data_o, pop_expect);
                    pop_expect++;
                    pop_cnt++;
                end
                if (clr_i) begin
                    mq.delete();
                end else begin
                    if (mq.size() > 0 && bif.dst_ready_i) void'(mq.pop_front());
                    if (m_mode != 2 && r) mq.push_back(bif.data_i);
                end
                m_outst = m_outst + int'(g) - int'(r);
                if (clr_i)            m_mode = 2;
                else if (m_mode == 2) m_mode = (m_outst == 0) ? 0 : 2;
                else                  m_mode = en_i ? 1 : 0;
            end
        end
    end

    // L2 responder: answers each grant, in order, 3 cycles later with incrementing data.
    initial begin : responder_proc
        resp_pipe = 3'b000;
        forever begin
            @(posedge clk);
            #2;
            if (!rstn_i) begin
                resp_pipe   = 3'b000;
                bif.valid_i = 1'b0;
            end else begin
                resp_pipe   = {resp_pipe[1:0], grant_seen};
                bif.valid_i = resp_pipe[2];
                if (resp_pipe[2]) begin
                    bif.data_i = resp_data;
                    resp_data++;
                end
            end
        end
    end

    initial begin : stimulus_proc
        int pops_before;
        rstn_i          = 1'b0;
        en_i            = 1'b0;
        clr_i           = 1'b0;
        bif.gnt_i       = 1'b0;
        bif.valid_i     = 1'b0;
        bif.data_i      = 32'h0;
        bif.dst_ready_i = 1'b0;
        resp_data       = 32'hA0;
        pop_expect      = 32'hA0;
        tick(3);
        rstn_i = 1'b1;
        tick(2);

        // 1: fill from empty with the peripheral stalled
        grant_cnt = 0;
        en_i      = 1'b1;
        bif.gnt_i = 1'b1;
        tick(20);
        check("t1_grants", grant_cnt, 8);
        check("t1_req_low", bif.req_o, 1'b0);
        check("t1_head", bif.dst_data_o, 32'hA0);
        check("t1_valid", bif.dst_valid_o, 1'b1);
        check("t1_model_size", mq.size(), 8);
        check("t1_model_tail", mq[7], 32'hA7);

        // 2: single pop reopens one credit, then stream across pointer wrap
        seq_chk         = 1'b1;
        pop_expect      = 32'hA0;
        pop_cnt         = 0;
        bif.dst_ready_i = 1'b1;
        tick(1);
        bif.dst_ready_i = 1'b0;
        check("t2_req_after_pop", bif.req_o, 1'b1);
        tick(1);
        check("t2_req_after_regrant", bif.req_o, 1'b0);
        bif.dst_ready_i = 1'b1;
        tick(30);
        check("t2_pops_ge20", (pop_cnt >= 20), 1'b1);

        // 3: grant and response in the same cycle, steady in-flight count
        for (int i = 0; i < 10; i++) begin
            tick(1);
            #2;
            check("t3_outst", dut.outst_r, 3);
            check("t3_gnt_and_valid", bif.req_o && bif.gnt_i && bif.valid_i, 1'b1);
        end

        // 5: channel disabled with two responses still in flight
        bif.gnt_i = 1'b0;
        tick(1);
        en_i = 1'b0;
        check("t5_outst", dut.outst_r, 2);
        tick(1);
        check("t5_req_low", bif.req_o, 1'b0);
        tick(10);
        check("t5_all_delivered", pop_expect, resp_data);
        check("t5_busy_low", busy_o, 1'b0);
        check("t5_valid_low", bif.dst_valid_o, 1'b0);

        // 4: flush with 5 stored and 3 outstanding
        seq_chk         = 1'b0;
        bif.dst_ready_i = 1'b0;
        en_i            = 1'b1;
        bif.gnt_i       = 1'b1;
        for (int i = 0; i < 30 && mq.size() != 5; i++) tick(1);
        check("t4_fill_bound", mq.size(), 5);
        check("t4_outst", dut.outst_r, 3);
        disc_cnt = 0;
        clr_i    = 1'b1;
        en_i     = 1'b0;
        tick(1);
        clr_i = 1'b0;
        check("t4_valid_cleared", bif.dst_valid_o, 1'b0);
        check("t4_busy_flushing", busy_o, 1'b1);
        tick(4);
        check("t4_discarded", disc_cnt, 3);
        check("t4_busy_low", busy_o, 1'b0);
        check("t4_idle", (dut.state_r == IDLE), 1'b1);

        // 6: asynchronous reset mid-stream, then restart
        pop_expect      = resp_data;
        seq_chk         = 1'b1;
        bif.dst_ready_i = 1'b1;
        en_i            = 1'b1;
        tick(8);
        #2;
        rstn_i = 1'b0;
        #1;
        seq_chk = 1'b0;
        check("t6_req_async", bif.req_o, 1'b0);
        check("t6_valid_async", bif.dst_valid_o, 1'b0);
        check("t6_data_async", bif.dst_data_o, 32'h0);
        check("t6_busy_async", busy_o, 1'b0);
        tick(2);
        rstn_i      = 1'b1;
        pop_expect  = resp_data;
        pops_before = pop_cnt;
        seq_chk     = 1'b1;
        tick(20);
        check("t6_restart_pops", ((pop_cnt - pops_before) >= 10), 1'b1);
        en_i = 1'b0;
        tick(10);
        check("t6_all_delivered", pop_expect, resp_data);
        check("t6_busy_low", busy_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
